uart_tx_frame: RTL and testbench



---
 rtl/uart_tx_frame.sv | 104 ++++++++++
 tb/tb_uart_tx_frame.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: serial UART transmitter running on the bit-rate clock.
// Sends a start bit, DATA_WIDTH data bits LSB first, an optional parity
// bit and a stop bit. Every clock cycle is one bit period.
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] i_p_data,
  input  logic                  i_data_valid,
  input  logic                  i_par_en,
  input  logic                  i_par_typ,
  output logic                  o_tx_out,
  output logic                  o_busy
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  par_en_q;
  logic                  par_bit_q;

  // Frame sequencer: each state drives the line level for the next bit period,
  // so the serial line and busy flag come straight from flops.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      o_tx_out  <= 1'b1;
      o_busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          o_tx_out <= 1'b1;
          o_busy   <= 1'b0;
          if (i_data_valid) begin
            shift_reg <= i_p_data;
            par_en_q  <= i_par_en;
            par_bit_q <= (^i_p_data) ^ i_par_typ;
            bit_cnt   <= '0;
            o_tx_out  <= 1'b0;
            o_busy    <= 1'b1;
            state     <= START;
          end
        end

        START: begin
          o_tx_out  <= shift_reg[0];
          shift_reg <= shift_reg >> 1;
          state     <= DATA;
        end

        DATA: begin
          if (bit_cnt == LAST_BIT) begin
            bit_cnt <= '0;
            if (par_en_q) begin
              o_tx_out <= par_bit_q;
              state    <= PARITY;
            end else begin
              o_tx_out <= 1'b1;
              state    <= STOP;
            end
          end else begin
            bit_cnt   <= bit_cnt + 1'b1;
            o_tx_out  <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
          end
        end

        PARITY: begin
          o_tx_out <= 1'b1;
          state    <= STOP;
        end

        STOP: begin
          o_tx_out <= 1'b1;
          o_busy   <= 1'b0;
          state    <= IDLE;
        end

        default: begin
          o_tx_out <= 1'b1;
          o_busy   <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: directed frames with a scoreboard of expected line bits.
// Stimulus pushes the bits each frame should produce; a monitor pops one bit
// per busy cycle and checks the idle line between frames.
module tb_uart_tx_frame;

  logic       i_clk;
  logic       i_rst_n;
  logic [7:0] i_p_data;
  logic       i_data_valid;
  logic       i_par_en;
  logic       i_par_typ;
  logic       o_tx_out;
  logic       o_busy;

  int   vectors;
  int   miscompares;
  logic sb[$];
  int   busy_run;
  int   idle_run;
  int   last_frame_len;
  int   last_gap;

  uart_tx_frame #(.DATA_WIDTH(8)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_p_data     (i_p_data),
    .i_data_valid (i_data_valid),
    .i_par_en     (i_par_en),
    .i_par_typ    (i_par_typ),
    .o_tx_out     (o_tx_out),
    .o_busy       (o_busy)
  );

  // Bit-rate clock, 10 time units per bit.
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] data, input logic valid,
                                input logic par_en, input logic par_typ);
    i_p_data     = data;
    i_data_valid = valid;
    i_par_en     = par_en;
    i_par_typ    = par_typ;
  endtask

  // Bits are written in transmission order, leftmost bit first on the line.
  task automatic push_bits(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) sb.push_back(bits[i]);
  endtask

  task automatic wait_drain(input string name);
    int cyc;
    cyc = 0;
    do begin
      @(negedge i_clk);
      #1;
      cyc++;
    end while ((sb.size() != 0 || o_busy) && cyc < 60);
    check_output({name, "_drain"}, sb.size(), 0);
  endtask

  task automatic send_frame(input string name, input logic [7:0] data,
                            input logic par_en, input logic par_typ,
                            input logic [15:0] bits, input int n);
    push_bits(bits, n);
    @(posedge i_clk);
    #1 apply_stimulus(data, 1'b1, par_en, par_typ);
    @(posedge i_clk);
    #1 apply_stimulus(data, 1'b0, par_en, par_typ);
    wait_drain(name);
    check_output({name, "_len"}, last_frame_len, n);
  endtask

  // Monitor: one expected bit per busy cycle, idle line high otherwise.
  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      check_output("reset_tx", o_tx_out, 1);
      check_output("reset_busy", o_busy, 0);
      sb.delete();
      busy_run = 0;
      idle_run = 0;
    end else if (o_busy) begin
      if (busy_run == 0) begin
        last_gap = idle_run;
        idle_run = 0;
      end
      busy_run++;
      check_output("busy_expected", (sb.size() != 0), 1);
      if (sb.size() != 0) check_output("tx_bit", o_tx_out, sb.pop_front());
    end else begin
      if (busy_run > 0) last_frame_len = busy_run;
      busy_run = 0;
      idle_run++;
      check_output("idle_line", o_tx_out, 1);
    end
  end

  // Watchdog so a stuck design still terminates.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus sequence.
  initial begin
    vectors        = 0;
    miscompares    = 0;
    busy_run       = 0;
    idle_run       = 0;
    last_frame_len = 0;
    last_gap       = 0;
    i_rst_n        = 1'b0;
    apply_stimulus(8'hFF, 1'b1, 1'b0, 1'b0);

    $display("[TB] reset dominance");
    repeat (10) @(posedge i_clk);
    #1;
    check_output("rst_hold_tx", o_tx_out, 1);
    check_output("rst_hold_busy", o_busy, 0);
    apply_stimulus(8'h00, 1'b0, 1'b0, 1'b0);
    i_rst_n = 1'b1;
    repeat (2) @(posedge i_clk);

    $display("[TB] no parity 0xA5");
    send_frame("a5_nopar", 8'hA5, 1'b0, 1'b0, 16'b0101001011, 10);

    $display("[TB] even parity 0xA5");
    send_frame("a5_even", 8'hA5, 1'b1, 1'b0, 16'b01010010101, 11);

    $display("[TB] odd parity 0xA5");
    send_frame("a5_odd", 8'hA5, 1'b1, 1'b1, 16'b01010010111, 11);

    $display("[TB] odd parity 0x00");
    send_frame("00_odd", 8'h00, 1'b1, 1'b1, 16'b00000000011, 11);

    $display("[TB] input isolation 0x3C");
    push_bits(16'b0001111001, 10);
    @(posedge i_clk);
    #1 apply_stimulus(8'h3C, 1'b1, 1'b0, 1'b0);
    @(posedge i_clk);
    #1 apply_stimulus(8'h3C, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge i_clk);
    #1 apply_stimulus(8'hFF, 1'b1, 1'b1, 1'b1);
    @(posedge i_clk);
    #1 apply_stimulus(8'hFF, 1'b0, 1'b1, 1'b1);
    wait_drain("iso");
    check_output("iso_len", last_frame_len, 10);
    repeat (6) @(negedge i_clk);
    #1 check_output("iso_no_second", o_busy, 0);

    $display("[TB] back to back 0x01 then 0x80");
    push_bits(16'b0100000001, 10);
    push_bits(16'b0000000011, 10);
    @(posedge i_clk);
    #1 apply_stimulus(8'h01, 1'b1, 1'b0, 1'b0);
    @(posedge i_clk);
    #1 apply_stimulus(8'h80, 1'b1, 1'b0, 1'b0);
    repeat (11) @(posedge i_clk);
    #1 apply_stimulus(8'h80, 1'b0, 1'b0, 1'b0);
    wait_drain("b2b");
    check_output("b2b_gap", last_gap, 1);
    check_output("b2b_len", last_frame_len, 10);

    $display("[TB] reset mid-frame 0x55");
    push_bits(16'b01010, 5);
    @(posedge i_clk);
    #1 apply_stimulus(8'h55, 1'b1, 1'b0, 1'b0);
    @(posedge i_clk);
    #1 apply_stimulus(8'h55, 1'b0, 1'b0, 1'b0);
    repeat (4) @(posedge i_clk);
    @(negedge i_clk);
    #2 i_rst_n = 1'b0;
    #1;
    check_output("abort_tx", o_tx_out, 1);
    check_output("abort_busy", o_busy, 0);
    check_output("abort_sb_empty", sb.size(), 0);
    sb.delete();
    repeat (3) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    repeat (15) @(negedge i_clk);
    #1;
    check_output("post_abort_tx", o_tx_out, 1);
    check_output("post_abort_busy", o_busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
